// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between instruction fetch and load/store.
// Load/store wins by default; a starvation counter hands fetch the port after STARVE_LIMIT losses.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [31:0]           i_req_addr,
   output logic                  i_rsp_valid,
   output logic [DATA_WIDTH-1:0] i_rsp_rdata,
   output logic                  i_rsp_err,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [31:0]           d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   output logic                  d_rsp_valid,
   output logic [DATA_WIDTH-1:0] d_rsp_rdata,
   output logic                  d_rsp_err,
   output logic                  mem_write_enable,
   output logic [31:0]           mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic       fetch_priority;
   logic       i_grant;
   logic       d_grant;
   logic       i_misaligned;
   logic       d_misaligned;

   assign i_misaligned = (i_req_addr[1:0] != 2'b00);
   assign d_misaligned = (d_req_addr[1:0] != 2'b00);

   // The counter value at the start of the cycle alone decides whether fetch overrides data.
   assign fetch_priority = (starve_cnt == LIMIT);
   assign d_grant        = d_req_valid && !(i_req_valid && fetch_priority);
   assign i_grant        = i_req_valid && !d_grant;

   assign i_req_ready = i_grant;
   assign d_req_ready = d_grant;

   always_comb begin
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_write_data   = '0;
      if (d_grant) begin
         mem_address      = d_req_addr;
         mem_write_data   = d_req_wdata;
         mem_write_enable = d_req_we && !d_misaligned;
      end else if (i_grant) begin
         mem_address = i_req_addr;
      end
   end

   // Counts consecutive cycles a waiting fetch loses; a dropped or served fetch starts over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!i_req_valid || i_grant) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Responses trail the grant by one cycle; a port without a grant sees all-zero response fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rsp_valid <= 1'b0;
         i_rsp_err   <= 1'b0;
         i_rsp_rdata <= '0;
         d_rsp_valid <= 1'b0;
         d_rsp_err   <= 1'b0;
         d_rsp_rdata <= '0;
      end else begin
         i_rsp_valid <= i_grant;
         i_rsp_err   <= i_grant && i_misaligned;
         i_rsp_rdata <= (i_grant && !i_misaligned) ? mem_read_data : '0;
         d_rsp_valid <= d_grant;
         d_rsp_err   <= d_grant && d_misaligned;
         d_rsp_rdata <= (d_grant && !d_req_we && !d_misaligned) ? mem_read_data : '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory behind the arbiter port.
// Expected values are hand-derived from the load/store-first, starve-after-4 arbitration rule.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_rsp_valid;
   logic [31:0] i_rsp_rdata;
   logic        i_rsp_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_rdata;
   logic        d_rsp_err;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] memArray [0:255];
   logic        clearMem;

   int compareCount;
   int failCount;

   mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_req_valid      (i_req_valid),
      .i_req_ready      (i_req_ready),
      .i_req_addr       (i_req_addr),
      .i_rsp_valid      (i_rsp_valid),
      .i_rsp_rdata      (i_rsp_rdata),
      .i_rsp_err        (i_rsp_err),
      .d_req_valid      (d_req_valid),
      .d_req_ready      (d_req_ready),
      .d_req_we         (d_req_we),
      .d_req_addr       (d_req_addr),
      .d_req_wdata      (d_req_wdata),
      .d_rsp_valid      (d_rsp_valid),
      .d_rsp_rdata      (d_rsp_rdata),
      .d_rsp_err        (d_rsp_err),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;

   // Single-port memory: combinational read, write on the rising edge; word 2 (0x8) is preloaded.
   always @(posedge clk) begin
      if (clearMem) begin
         for (int k = 0; k < 256; k++) memArray[k] <= '0;
         memArray[2] <= 32'h12345678;
      end else if (mem_write_enable) begin
         memArray[mem_address[9:2]] <= mem_write_data;
      end
   end

   assign mem_read_data = memArray[mem_address[9:2]];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
      i_req_valid = iv;
      i_req_addr  = ia;
      d_req_valid = dv;
      d_req_we    = dwe;
      d_req_addr  = da;
      d_req_wdata = dwd;
      #1;
   endtask

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   int   ld;
   int   fi;
   logic isF;

   initial begin
      compareCount = 0;
      failCount    = 0;
      clearMem     = 1'b1;
      rst_n        = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset state
      stepCycle();
      clearMem = 1'b0;
      stepCycle();
      checkOutput("rst_i_rsp_valid", i_rsp_valid, 0);
      checkOutput("rst_d_rsp_valid", d_rsp_valid, 0);
      checkOutput("rst_i_rsp_rdata", i_rsp_rdata, 0);
      checkOutput("rst_d_rsp_err", d_rsp_err, 0);
      checkOutput("rst_mem_we", mem_write_enable, 0);
      checkOutput("rst_mem_addr", mem_address, 0);
      rst_n = 1'b1;

      // Fetch alone at 0x0
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("fetch_i_ready", i_req_ready, 1);
      checkOutput("fetch_d_ready", d_req_ready, 0);
      stepCycle();
      checkOutput("fetch_rsp_valid", i_rsp_valid, 1);
      checkOutput("fetch_rsp_rdata", i_rsp_rdata, 0);
      checkOutput("fetch_rsp_err", i_rsp_err, 0);
      checkOutput("fetch_d_rsp_valid", d_rsp_valid, 0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("idle_i_ready", i_req_ready, 0);
      checkOutput("idle_mem_we", mem_write_enable, 0);
      checkOutput("idle_mem_addr", mem_address, 0);
      checkOutput("idle_mem_wdata", mem_write_data, 0);
      stepCycle();
      checkOutput("idle_i_rsp_valid", i_rsp_valid, 0);

      // Store then load at 0x4
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
      checkOutput("st_d_ready", d_req_ready, 1);
      checkOutput("st_mem_we", mem_write_enable, 1);
      checkOutput("st_mem_addr", mem_address, 32'h4);
      checkOutput("st_mem_wdata", mem_write_data, 32'hDEADBEEF);
      stepCycle();
      checkOutput("st_rsp_valid", d_rsp_valid, 1);
      checkOutput("st_rsp_rdata", d_rsp_rdata, 0);
      checkOutput("st_rsp_err", d_rsp_err, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      checkOutput("ld_mem_we", mem_write_enable, 0);
      stepCycle();
      checkOutput("ld_rsp_valid", d_rsp_valid, 1);
      checkOutput("ld_rsp_rdata", d_rsp_rdata, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      // Starvation: fetch at 0x8 wins on its 5th cycle, data resumes right after
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
         checkOutput("starve_i_ready", i_req_ready, (c == 4) ? 1 : 0);
         checkOutput("starve_d_ready", d_req_ready, (c == 4) ? 0 : 1);
         if (c == 4) checkOutput("starve_mem_addr", mem_address, 32'h8);
         stepCycle();
         checkOutput("starve_i_rsp_valid", i_rsp_valid, (c == 4) ? 1 : 0);
         checkOutput("starve_d_rsp_valid", d_rsp_valid, (c == 4) ? 0 : 1);
         if (c == 4) checkOutput("starve_i_rdata", i_rsp_rdata, 32'h12345678);
         else        checkOutput("starve_d_rdata", d_rsp_rdata, 32'hDEADBEEF);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      // Misaligned store, then the word at 0x4 must be untouched; misaligned fetch
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 32'hCAFEBABE);
      checkOutput("mis_st_ready", d_req_ready, 1);
      checkOutput("mis_st_mem_we", mem_write_enable, 0);
      stepCycle();
      checkOutput("mis_st_rsp_valid", d_rsp_valid, 1);
      checkOutput("mis_st_rsp_err", d_rsp_err, 1);
      checkOutput("mis_st_rsp_rdata", d_rsp_rdata, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      stepCycle();
      checkOutput("mis_ld_rdata", d_rsp_rdata, 32'hDEADBEEF);
      checkOutput("mis_ld_err", d_rsp_err, 0);
      applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("mis_f_ready", i_req_ready, 1);
      stepCycle();
      checkOutput("mis_f_rsp_valid", i_rsp_valid, 1);
      checkOutput("mis_f_rsp_err", i_rsp_err, 1);
      checkOutput("mis_f_rsp_rdata", i_rsp_rdata, 0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      // Burst of 64 stores of i*100 to i<<2
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'(i << 2), 32'(i * 100));
         checkOutput("bst_d_ready", d_req_ready, 1);
         checkOutput("bst_mem_we", mem_write_enable, 1);
         stepCycle();
         checkOutput("bst_rsp_valid", d_rsp_valid, 1);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      // 64 loads with fetch contending: four data grants, then one fetch grant, repeating
      for (int c = 0; c < 80; c++) begin
         isF = ((c % 5) == 4);
         ld  = c - (c / 5);
         fi  = c / 5;
         applyStimulus(1'b1, 32'((fi % 64) << 2), 1'b1, 1'b0, 32'(ld << 2), 32'h0);
         checkOutput("bld_i_ready", i_req_ready, isF ? 1 : 0);
         checkOutput("bld_d_ready", d_req_ready, isF ? 0 : 1);
         stepCycle();
         checkOutput("bld_i_rsp_valid", i_rsp_valid, isF ? 1 : 0);
         checkOutput("bld_d_rsp_valid", d_rsp_valid, isF ? 0 : 1);
         if (isF) checkOutput("bld_i_rdata", i_rsp_rdata, 32'((fi % 64) * 100));
         else     checkOutput("bld_d_rdata", d_rsp_rdata, 32'(ld * 100));
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      // Reset pulsed mid-burst with the starvation counter part-way up
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
         checkOutput("prerst_d_ready", d_req_ready, 1);
         stepCycle();
      end
      checkOutput("prerst_d_rsp_valid", d_rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_i_rsp_valid", i_rsp_valid, 0);
      checkOutput("midrst_d_rsp_valid", d_rsp_valid, 0);
      checkOutput("midrst_d_rsp_rdata", d_rsp_rdata, 0);
      stepCycle();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
         checkOutput("postrst_i_ready", i_req_ready, (c == 4) ? 1 : 0);
         checkOutput("postrst_d_ready", d_req_ready, (c == 4) ? 0 : 1);
         stepCycle();
         checkOutput("postrst_d_rsp_valid", d_rsp_valid, (c == 4) ? 0 : 1);
         if (c == 4) checkOutput("postrst_i_rdata", i_rsp_rdata, 32'd200);
         else        checkOutput("postrst_d_rdata", d_rsp_rdata, 32'd100);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
